// File: rtl/alu_mult_result_queue_if.sv
// data_interface: one valid/ack producer stream carrying a DATA_WIDTH word.
//   valid - producer has a word on data this cycle
//   ack   - consumer accepts the word; a transfer happens when valid && ack
//   data  - payload, meaningful only while valid is high
// Modports:
//   producer - drives valid and data, receives ack
//   consumer - receives valid and data, drives ack
interface data_interface #(
  parameter int DATA_WIDTH = 32
);
  logic                  valid;
  logic                  ack;
  logic [DATA_WIDTH-1:0] data;

  modport producer (output valid, output data, input ack);
  modport consumer (input valid, input data, output ack);
endinterface

// File: rtl/alu_mult_result_queue.sv
// alu_mult_result_queue
// Buffers {overflow, result} product pairs from the Toom-Cook multiplier.
// Both input streams are joined into one DEPTH-entry queue; the head entry is
// re-presented on two output streams that drain independently. An entry
// retires only after both halves have been taken.
// Ports:
//   clock        - rising-edge clock
//   rst_n        - asynchronous active-low reset
//   in_result    - low product word in (consumer side)
//   in_overflow  - high product word in (consumer side)
//   out_result   - queued low word out (producer side)
//   out_overflow - queued high word out (producer side)
//   fill_level   - number of occupied entries, 0..DEPTH
module alu_mult_result_queue #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                   clock,
  input  logic                   rst_n,
  data_interface.consumer        in_result,
  data_interface.consumer        in_overflow,
  data_interface.producer        out_result,
  data_interface.producer        out_overflow,
  output logic [LEVEL_WIDTH-1:0] fill_level
);

  localparam int PTR_WIDTH = $clog2(DEPTH);
  localparam logic [LEVEL_WIDTH-1:0] FULL_COUNT = LEVEL_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0]  res_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  ovf_mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [LEVEL_WIDTH-1:0] count;
  logic                   res_taken;
  logic                   ovf_taken;

  logic push;
  logic pop;
  logic has_data;
  logic res_xfer;
  logic ovf_xfer;

  // Join and drain decisions. push is the raw join condition used by the
  // state registers; the ack outputs are additionally gated by rst_n so they
  // read 0 while reset is held, without routing rst_n into any flop D input.
  // Full/empty come from count only; pointer equality is ambiguous.
  always_comb begin
    push     = 1'b0;
    pop      = 1'b0;
    has_data = 1'b0;
    res_xfer = 1'b0;
    ovf_xfer = 1'b0;

    push     = in_result.valid && in_overflow.valid && (count != FULL_COUNT);
    has_data = (count != '0);
    res_xfer = has_data && !res_taken && out_result.ack;
    ovf_xfer = has_data && !ovf_taken && out_overflow.ack;
    pop      = (res_taken || res_xfer) && (ovf_taken || ovf_xfer);
  end

  assign in_result.ack   = push && rst_n;
  assign in_overflow.ack = push && rst_n;

  // Each half is offered until it has been taken; data is read straight from
  // the head entry.
  assign out_result.valid   = has_data && !res_taken;
  assign out_overflow.valid = has_data && !ovf_taken;
  assign out_result.data    = res_mem[rd_ptr];
  assign out_overflow.data  = ovf_mem[rd_ptr];

  assign fill_level = count;

  // Storage is deliberately not reset: after reset count is 0, so nothing
  // in it is ever presented until it has been rewritten.
  always_ff @(posedge clock) begin
    if (push) begin
      res_mem[wr_ptr] <= in_result.data;
      ovf_mem[wr_ptr] <= in_overflow.data;
    end
  end

  // Pointers and occupancy. Pointers are log2(DEPTH) bits and wrap on their
  // own; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Taken flags remember which half of the head entry has already gone out.
  // Retiring the entry clears both, including when the last half and the
  // pop land on the same edge.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      res_taken <= 1'b0;
      ovf_taken <= 1'b0;
    end else if (pop) begin
      res_taken <= 1'b0;
      ovf_taken <= 1'b0;
    end else begin
      if (res_xfer) begin
        res_taken <= 1'b1;
      end
      if (ovf_xfer) begin
        ovf_taken <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mult_result_queue.sv
module tb_alu_mult_result_queue;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clock;
  logic          rst_n;
  logic [LW-1:0] fill_level;

  data_interface #(.DATA_WIDTH(DW)) in_res_if ();
  data_interface #(.DATA_WIDTH(DW)) in_ovf_if ();
  data_interface #(.DATA_WIDTH(DW)) out_res_if ();
  data_interface #(.DATA_WIDTH(DW)) out_ovf_if ();

  alu_mult_result_queue #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .in_result(in_res_if),
    .in_overflow(in_ovf_if),
    .out_result(out_res_if),
    .out_overflow(out_ovf_if),
    .fill_level(fill_level)
  );

  int checks = 0;
  int errors = 0;

  // Free-running clock: rising edges at 5, 15, 25, ...; inputs change on the
  // falling edge and outputs are sampled shortly after.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic          in_rv;
    logic          in_ov;
    logic [DW-1:0] in_rd;
    logic [DW-1:0] in_od;
    logic          out_ra;
    logic          out_oa;
    logic          e_ack;
    logic          e_rv;
    logic          e_ov;
    logic [DW-1:0] e_rd;
    logic [DW-1:0] e_od;
    logic [LW-1:0] e_fill;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(logic in_rv, logic in_ov, logic [DW-1:0] in_rd,
                                  logic [DW-1:0] in_od, logic out_ra, logic out_oa,
                                  logic e_ack, logic e_rv, logic e_ov,
                                  logic [DW-1:0] e_rd, logic [DW-1:0] e_od,
                                  logic [LW-1:0] e_fill);
    vec_t v;
    v.in_rv = in_rv;   v.in_ov = in_ov;   v.in_rd = in_rd;  v.in_od = in_od;
    v.out_ra = out_ra; v.out_oa = out_oa;
    v.e_ack = e_ack;   v.e_rv = e_rv;     v.e_ov = e_ov;
    v.e_rd = e_rd;     v.e_od = e_od;     v.e_fill = e_fill;
    vecs.push_back(v);
  endfunction

  task automatic checkValue(input string name, input logic [DW-1:0] actual,
                            input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic in_rv, input logic in_ov,
                               input logic [DW-1:0] in_rd, input logic [DW-1:0] in_od,
                               input logic out_ra, input logic out_oa);
    in_res_if.valid = in_rv;
    in_ovf_if.valid = in_ov;
    in_res_if.data  = in_rd;
    in_ovf_if.data  = in_od;
    out_res_if.ack  = out_ra;
    out_ovf_if.ack  = out_oa;
  endtask

  task automatic checkOutput(input string tag, input logic e_ack, input logic e_rv,
                             input logic e_ov, input logic [DW-1:0] e_rd,
                             input logic [DW-1:0] e_od, input logic [LW-1:0] e_fill);
    checkValue({tag, " in_result.ack"}, DW'(in_res_if.ack), DW'(e_ack));
    checkValue({tag, " in_overflow.ack"}, DW'(in_ovf_if.ack), DW'(e_ack));
    checkValue({tag, " out_result.valid"}, DW'(out_res_if.valid), DW'(e_rv));
    checkValue({tag, " out_overflow.valid"}, DW'(out_ovf_if.valid), DW'(e_ov));
    if (e_rv) checkValue({tag, " out_result.data"}, out_res_if.data, e_rd);
    if (e_ov) checkValue({tag, " out_overflow.data"}, out_ovf_if.data, e_od);
    checkValue({tag, " fill_level"}, DW'(fill_level), DW'(e_fill));
  endtask

  // Output hold rule: a word offered but not accepted must still be offered,
  // unchanged, one cycle later. Sampled 2 time units before each rising edge.
  logic          prev_rv, prev_ra, prev_ov, prev_oa;
  logic [DW-1:0] prev_rd, prev_od;
  initial begin
    prev_rv = 1'b0; prev_ra = 1'b0; prev_ov = 1'b0; prev_oa = 1'b0;
    prev_rd = '0;   prev_od = '0;
  end

  always @(negedge clock) begin
    #3;
    if (!rst_n) begin
      prev_rv = 1'b0;
      prev_ov = 1'b0;
    end else begin
      if (prev_rv && !prev_ra) begin
        checkValue("hold out_result.valid", DW'(out_res_if.valid), DW'(1'b1));
        checkValue("hold out_result.data", out_res_if.data, prev_rd);
      end
      if (prev_ov && !prev_oa) begin
        checkValue("hold out_overflow.valid", DW'(out_ovf_if.valid), DW'(1'b1));
        checkValue("hold out_overflow.data", out_ovf_if.data, prev_od);
      end
      prev_rv = out_res_if.valid; prev_ra = out_res_if.ack; prev_rd = out_res_if.data;
      prev_ov = out_ovf_if.valid; prev_oa = out_ovf_if.ack; prev_od = out_ovf_if.data;
    end
  end

  initial begin
    logic [DW-1:0] exp_r[$];
    logic [DW-1:0] exp_o[$];
    int            model_count;
    int            sent;
    int            recv;
    int            cycles;
    logic          gap;
    logic          exp_ack;
    logic          exp_valid;

    // Single pass, fill to full, skewed drain, join mismatch, reverse skew.
    add_vec(1,1,32'h6,32'h0,1,1,            1,0,0,32'h0,32'h0,0);
    add_vec(0,0,32'h0,32'h0,1,1,            0,1,1,32'h6,32'h0,1);
    add_vec(0,0,32'h0,32'h0,0,0,            0,0,0,32'h0,32'h0,0);
    add_vec(1,1,32'd1,~32'd1,0,0,           1,0,0,32'h0,32'h0,0);
    add_vec(1,1,32'd2,~32'd2,0,0,           1,1,1,32'd1,~32'd1,1);
    add_vec(1,1,32'd3,~32'd3,0,0,           1,1,1,32'd1,~32'd1,2);
    add_vec(1,1,32'd4,~32'd4,0,0,           1,1,1,32'd1,~32'd1,3);
    add_vec(1,1,32'd5,~32'd5,0,0,           0,1,1,32'd1,~32'd1,4);
    add_vec(1,1,32'd5,~32'd5,1,1,           0,1,1,32'd1,~32'd1,4);
    add_vec(1,1,32'd5,~32'd5,0,0,           1,1,1,32'd2,~32'd2,3);
    add_vec(0,0,32'h0,32'h0,1,1,            0,1,1,32'd2,~32'd2,4);
    add_vec(0,0,32'h0,32'h0,1,1,            0,1,1,32'd3,~32'd3,3);
    add_vec(0,0,32'h0,32'h0,1,1,            0,1,1,32'd4,~32'd4,2);
    add_vec(0,0,32'h0,32'h0,1,1,            0,1,1,32'd5,~32'd5,1);
    add_vec(0,0,32'h0,32'h0,0,0,            0,0,0,32'h0,32'h0,0);
    add_vec(1,1,32'hA,32'hB,0,0,            1,0,0,32'h0,32'h0,0);
    add_vec(1,1,32'hC,32'hD,0,0,            1,1,1,32'hA,32'hB,1);
    add_vec(0,0,32'h0,32'h0,1,0,            0,1,1,32'hA,32'hB,2);
    add_vec(0,0,32'h0,32'h0,1,0,            0,0,1,32'h0,32'hB,2);
    add_vec(0,0,32'h0,32'h0,0,1,            0,0,1,32'h0,32'hB,2);
    add_vec(0,0,32'h0,32'h0,0,0,            0,1,1,32'hC,32'hD,1);
    add_vec(0,0,32'h0,32'h0,1,1,            0,1,1,32'hC,32'hD,1);
    add_vec(1,0,32'h11,32'h22,0,0,          0,0,0,32'h0,32'h0,0);
    add_vec(1,0,32'h11,32'h22,0,0,          0,0,0,32'h0,32'h0,0);
    add_vec(1,0,32'h11,32'h22,0,0,          0,0,0,32'h0,32'h0,0);
    add_vec(1,1,32'h11,32'h22,0,0,          1,0,0,32'h0,32'h0,0);
    add_vec(0,0,32'h0,32'h0,0,0,            0,1,1,32'h11,32'h22,1);
    add_vec(0,0,32'h0,32'h0,0,1,            0,1,1,32'h11,32'h22,1);
    add_vec(0,0,32'h0,32'h0,0,1,            0,1,0,32'h11,32'h0,1);
    add_vec(0,0,32'h0,32'h0,1,0,            0,1,0,32'h11,32'h0,1);
    add_vec(0,0,32'h0,32'h0,0,0,            0,0,0,32'h0,32'h0,0);

    // Reset with both input valids high: acks must still read 0.
    rst_n = 1'b0;
    applyStimulus(1, 1, 32'h5, 32'h7, 1, 1);
    repeat (2) @(negedge clock);
    #1;
    checkOutput("reset", 0, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, '0, '0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      applyStimulus(vecs[i].in_rv, vecs[i].in_ov, vecs[i].in_rd, vecs[i].in_od,
                    vecs[i].out_ra, vecs[i].out_oa);
      #1;
      checkOutput($sformatf("vec%0d", i), vecs[i].e_ack, vecs[i].e_rv, vecs[i].e_ov,
                  vecs[i].e_rd, vecs[i].e_od, vecs[i].e_fill);
    end

    // Streaming with both consumers always acking and random input gaps.
    model_count = 0; sent = 0; recv = 0; cycles = 0;
    while (recv < 20 && cycles < 300) begin
      @(negedge clock);
      cycles++;
      gap = ($urandom_range(0, 3) == 0) || (sent >= 20);
      applyStimulus(!gap, !gap, 32'h100 + DW'(sent), ~(32'h100 + DW'(sent)), 1, 1);
      #1;
      exp_ack   = !gap && (model_count != DEPTH);
      exp_valid = (model_count != 0);
      checkValue("stream in_result.ack", DW'(in_res_if.ack), DW'(exp_ack));
      checkValue("stream out_result.valid", DW'(out_res_if.valid), DW'(exp_valid));
      checkValue("stream out_overflow.valid", DW'(out_ovf_if.valid), DW'(exp_valid));
      if (exp_valid && exp_r.size() > 0) begin
        checkValue("stream out_result.data", out_res_if.data, exp_r[0]);
        checkValue("stream out_overflow.data", out_ovf_if.data, exp_o[0]);
      end
      checkValue("stream fill_level", DW'(fill_level), DW'(model_count));
      @(posedge clock);
      if (exp_ack) begin
        exp_r.push_back(32'h100 + DW'(sent));
        exp_o.push_back(~(32'h100 + DW'(sent)));
        sent++;
      end
      if (exp_valid && exp_r.size() > 0) begin
        void'(exp_r.pop_front());
        void'(exp_o.pop_front());
        recv++;
      end
      model_count = exp_r.size();
    end
    checks++;
    if (recv < 20) begin
      errors++;
      $display("[TB] FAIL stream budget received=%0d required=20", recv);
    end

    // Mid-operation reset: three entries queued, result half of head taken.
    @(negedge clock);
    applyStimulus(1, 1, 32'h31, 32'h41, 0, 0);
    @(negedge clock);
    applyStimulus(1, 1, 32'h32, 32'h42, 0, 0);
    @(negedge clock);
    applyStimulus(1, 1, 32'h33, 32'h43, 0, 0);
    @(negedge clock);
    applyStimulus(0, 0, '0, '0, 1, 0);
    #1;
    checkOutput("pre-reset", 0, 1, 1, 32'h31, 32'h41, 3);
    @(negedge clock);
    applyStimulus(1, 1, 32'h55, 32'h66, 0, 0);
    #1;
    checkOutput("pre-reset taken", 1, 0, 1, '0, 32'h41, 3);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset", 0, 0, 0, '0, '0, '0);
    @(negedge clock);
    applyStimulus(0, 0, '0, '0, 0, 0);
    rst_n = 1'b1;
    #1;
    checkOutput("post-reset idle", 0, 0, 0, '0, '0, '0);
    @(negedge clock);
    applyStimulus(1, 1, 32'h77, 32'h88, 0, 0);
    #1;
    checkOutput("post-reset push", 1, 0, 0, '0, '0, '0);
    @(negedge clock);
    applyStimulus(0, 0, '0, '0, 1, 1);
    #1;
    checkOutput("post-reset data", 0, 1, 1, 32'h77, 32'h88, 1);
    @(negedge clock);
    applyStimulus(0, 0, '0, '0, 0, 0);
    #1;
    checkOutput("post-reset empty", 0, 0, 0, '0, '0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
